// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAw         = 8;
  localparam int unsigned DefDw         = 16;
  localparam int unsigned DefHostStreak = 4;

  typedef enum logic {
    StArb,
    StLock
  } arb_state_e;

  // Which requester owns the read data coming back from memory next cycle.
  typedef enum logic [1:0] {
    TagNone,
    TagHost,
    TagCpu
  } rd_tag_e;

endpackage

// File: rtl/mem_arb_fairness.sv
// Host streak counter: once the host has won HOST_STREAK consecutive grants
// against a waiting CPU, the CPU is given the next slot.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int unsigned HOST_STREAK = DefHostStreak
) (
  input  logic clk,
  input  logic Rst,
  input  logic cpu_req,
  input  logic host_gnt,
  input  logic cpu_gnt,
  input  logic excl,
  output logic cpu_override
);

  localparam int unsigned SW = $clog2(HOST_STREAK + 1);
  localparam logic [SW-1:0] StreakMax = SW'(HOST_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  // Next streak: held at zero under exclusive host ownership or when the CPU is not waiting.
  always_comb begin
    streak_d = streak_q;
    if (excl || !cpu_req || cpu_gnt) begin
      streak_d = '0;
    end else if (host_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign cpu_override = cpu_req && (streak_q == StreakMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing the single-port unified memory between the
// CPU and the host loader/debug port, with host lock and CPU fairness.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = DefAw,
  parameter int unsigned DW          = DefDw,
  parameter int unsigned HOST_STREAK = DefHostStreak
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          locked,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q;
  rd_tag_e       rd_tag_q, rd_tag_d;
  logic [DW-1:0] host_hold_q, cpu_hold_q;
  logic          excl;
  logic          cpu_override;

  // A lock request excludes the CPU in the same cycle, before the FSM reaches LOCK.
  assign excl = (state_q == StLock) || host_lock;

  mem_arb_fairness #(
    .HOST_STREAK (HOST_STREAK)
  ) u_fairness (
    .clk          (clk),
    .Rst          (Rst),
    .cpu_req      (cpu_req),
    .host_gnt     (host_gnt),
    .cpu_gnt      (cpu_gnt),
    .excl         (excl),
    .cpu_override (cpu_override)
  );

  // Grants, stall and memory mux; everything is forced quiet while reset is asserted.
  always_comb begin
    host_gnt  = !Rst && host_req && (excl || !cpu_override);
    cpu_gnt   = !Rst && cpu_req && !excl && (!host_req || cpu_override);
    cpu_stall = !Rst && cpu_req && !cpu_gnt;
    mem_addr  = host_gnt ? host_addr : cpu_addr;
    mem_wdata = host_gnt ? host_wdata : cpu_wdata;
    mem_we    = (host_gnt && host_we) || (cpu_gnt && cpu_we);
  end

  // Tag the owner of a read issued this cycle.
  always_comb begin
    rd_tag_d = TagNone;
    if (host_gnt && !host_we) begin
      rd_tag_d = TagHost;
    end else if (cpu_gnt && !cpu_we) begin
      rd_tag_d = TagCpu;
    end
  end

  // ARB/LOCK state machine.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StArb;
    end else begin
      unique case (state_q)
        StArb:   if (host_lock)  state_q <= StLock;
        StLock:  if (!host_lock) state_q <= StArb;
        default: state_q <= StArb;
      endcase
    end
  end

  // Read tag and held read data; reset drops any read still in flight.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rd_tag_q    <= TagNone;
      host_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      rd_tag_q <= rd_tag_d;
      if (host_rvalid) host_hold_q <= mem_rdata;
      if (cpu_rvalid)  cpu_hold_q  <= mem_rdata;
    end
  end

  assign locked      = (state_q == StLock);
  assign host_rvalid = (rd_tag_q == TagHost);
  assign cpu_rvalid  = (rd_tag_q == TagCpu);
  assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned HS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we, host_lock;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        cpu_stall, locked;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW          (8),
    .DW          (16),
    .HOST_STREAK (HS)
  ) dut (
    .clk         (clk),
    .Rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .locked      (locked),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  // Environment: 256x16 synchronous, write-first memory.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state: memory contents, lock flag, host win streak, read in flight.
  logic [15:0] model_mem [256];
  bit          m_lock;
  int          m_streak;
  int          m_pend;       // 0 none, 1 host, 2 cpu
  logic [15:0] m_pend_data;
  logic [15:0] m_host_hold, m_cpu_hold;

  bit          exp_hg, exp_cg, exp_stall, exp_we, exp_hrv, exp_crv;
  logic [7:0]  exp_addr;
  logic [15:0] exp_wdata, exp_hrd, exp_crd;

  task automatic model_reset();
    m_lock      = 0;
    m_streak    = 0;
    m_pend      = 0;
    m_pend_data = 16'h0;
    m_host_hold = 16'h0;
    m_cpu_hold  = 16'h0;
  endtask

  // Who should win this cycle, and what each output should show.
  task automatic model_eval();
    bit excl, cpu_turn;
    excl      = m_lock || host_lock;
    cpu_turn  = cpu_req && !excl && (m_streak >= int'(HS));
    exp_hg    = host_req && !cpu_turn;
    exp_cg    = cpu_req && !excl && !exp_hg;
    exp_stall = cpu_req && !exp_cg;
    exp_we    = (exp_hg && host_we) || (exp_cg && cpu_we);
    exp_addr  = exp_hg ? host_addr : cpu_addr;
    exp_wdata = exp_hg ? host_wdata : cpu_wdata;
    exp_hrv   = (m_pend == 1);
    exp_crv   = (m_pend == 2);
    exp_hrd   = exp_hrv ? m_pend_data : m_host_hold;
    exp_crd   = exp_crv ? m_pend_data : m_cpu_hold;
  endtask

  // Apply the effects of this cycle's access at the clock edge.
  task automatic model_commit();
    bit excl;
    excl = m_lock || host_lock;
    if (exp_hrv) m_host_hold = m_pend_data;
    if (exp_crv) m_cpu_hold = m_pend_data;
    m_pend = 0;
    if (exp_hg) begin
      if (host_we) model_mem[host_addr] = host_wdata;
      else begin
        m_pend      = 1;
        m_pend_data = model_mem[host_addr];
      end
    end else if (exp_cg) begin
      if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
      else begin
        m_pend      = 2;
        m_pend_data = model_mem[cpu_addr];
      end
    end
    if (excl || !cpu_req || exp_cg) m_streak = 0;
    else if (exp_hg && m_streak < int'(HS)) m_streak++;
    m_lock = host_lock;
  endtask

  task automatic eval_cycle();
    #1;
    model_eval();
    check_eq("host_gnt", 32'(host_gnt), 32'(exp_hg));
    check_eq("cpu_gnt", 32'(cpu_gnt), 32'(exp_cg));
    check_eq("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
    check_eq("locked", 32'(locked), 32'(m_lock));
    check_eq("mem_we", 32'(mem_we), 32'(exp_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check_eq("host_rvalid", 32'(host_rvalid), 32'(exp_hrv));
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
    check_eq("host_rdata", 32'(host_rdata), 32'(exp_hrd));
    check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_host_gnt"}, 32'(host_gnt), 32'h0);
    check_eq({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'h0);
    check_eq({tag, "_host_rvalid"}, 32'(host_rvalid), 32'h0);
    check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check_eq({tag, "_host_rdata"}, 32'(host_rdata), 32'h0);
    check_eq({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    check_eq({tag, "_locked"}, 32'(locked), 32'h0);
    check_eq({tag, "_cpu_stall"}, 32'(cpu_stall), 32'h0);
  endtask

  // Called just after a rising edge; releases reset just after a later rising edge.
  task automatic reset_pulse(input string tag, input int cycles);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_outputs(tag);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
    model_reset();
    rst       = 1'b1;
    host_lock = 1'b0;
    set_host(1'b0, 1'b0, 8'h00, 16'h0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
    @(posedge clk);
    #1;
    reset_pulse("reset", 2);

    // 1: host write then host read of 0x80.
    set_host(1'b1, 1'b1, 8'h80, 16'h0001);
    eval_cycle();
    check_eq("t1_wr_gnt", 32'(host_gnt), 32'h1);
    end_cycle();
    set_host(1'b1, 1'b0, 8'h80, 16'h0);
    eval_cycle();
    check_eq("t1_rd_gnt", 32'(host_gnt), 32'h1);
    end_cycle();
    set_host(1'b0, 1'b0, 8'h00, 16'h0);
    eval_cycle();
    check_eq("t1_rvalid", 32'(host_rvalid), 32'h1);
    check_eq("t1_rdata", 32'(host_rdata), 32'h0001);
    check_eq("t1_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    end_cycle();

    // 2: both requesting continuously; CPU wins the fifth slot.
    set_host(1'b1, 1'b0, 8'h90, 16'h0);
    set_cpu(1'b1, 1'b0, 8'h91, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      eval_cycle();
      check_eq($sformatf("t2_host_gnt_c%0d", c), 32'(host_gnt), 32'(c != 5));
      check_eq($sformatf("t2_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'(c == 5));
      check_eq($sformatf("t2_stall_c%0d", c), 32'(cpu_stall), 32'(c != 5));
      end_cycle();
    end

    // 3: lock with CPU waiting for 10 cycles, then release.
    set_host(1'b0, 1'b0, 8'h00, 16'h0);
    set_cpu(1'b1, 1'b0, 8'h92, 16'h0);
    host_lock = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      eval_cycle();
      check_eq($sformatf("t3_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'h0);
      if (c > 1) check_eq($sformatf("t3_locked_c%0d", c), 32'(locked), 32'h1);
      end_cycle();
    end
    host_lock = 1'b0;
    eval_cycle();
    check_eq("t3_release_cpu_gnt", 32'(cpu_gnt), 32'h0);
    end_cycle();
    eval_cycle();
    check_eq("t3_first_arb_cpu_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("t3_first_arb_locked", 32'(locked), 32'h0);
    end_cycle();

    // 4: preload 0x81 then CPU read.
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
    set_host(1'b1, 1'b1, 8'h81, 16'h0021);
    eval_cycle();
    end_cycle();
    set_host(1'b0, 1'b0, 8'h00, 16'h0);
    set_cpu(1'b1, 1'b0, 8'h81, 16'h0);
    eval_cycle();
    check_eq("t4_cpu_gnt", 32'(cpu_gnt), 32'h1);
    end_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
    eval_cycle();
    check_eq("t4_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check_eq("t4_cpu_rdata", 32'(cpu_rdata), 32'h0021);
    check_eq("t4_host_rvalid", 32'(host_rvalid), 32'h0);
    end_cycle();

    // 5: reset right after a CPU read grant discards the read.
    set_cpu(1'b1, 1'b0, 8'h80, 16'h0);
    eval_cycle();
    check_eq("t5_cpu_gnt", 32'(cpu_gnt), 32'h1);
    end_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
    reset_pulse("t5_reset", 2);
    eval_cycle();
    check_eq("t5_after_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check_eq("t5_after_locked", 32'(locked), 32'h0);
    end_cycle();

    // 6: host write immediately followed by CPU read of the same address.
    set_host(1'b1, 1'b1, 8'h84, 16'h0700);
    eval_cycle();
    end_cycle();
    set_host(1'b0, 1'b0, 8'h00, 16'h0);
    set_cpu(1'b1, 1'b0, 8'h84, 16'h0);
    eval_cycle();
    check_eq("t6_cpu_gnt", 32'(cpu_gnt), 32'h1);
    end_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
    eval_cycle();
    check_eq("t6_cpu_rdata", 32'(cpu_rdata), 32'h0700);
    end_cycle();

    // Randomized traffic on a small address window; requests held until granted.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) reset_pulse("rand_reset", 1);
      if (!host_req || exp_hg) begin
        host_req   = ($urandom_range(0, 3) != 0);
        host_we    = 1'($urandom);
        host_addr  = 8'h80 | 8'($urandom_range(0, 7));
        host_wdata = 16'($urandom);
      end
      if (!cpu_req || exp_cg) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom);
        cpu_addr  = 8'h80 | 8'($urandom_range(0, 7));
        cpu_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 19) == 0) host_lock = ~host_lock;
      eval_cycle();
      end_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
